// File: rtl/dmem_ctrl_pkg.sv
// rtl/dmem_ctrl_pkg.sv - shared types and funct3 codes for the data memory access controller
//
// Purpose : FSM state encoding and RV32 load/store size codes used by
//           dmem_access_ctrl and dmem_lane_align.
// Ports   : none (package).
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane extraction, store merge and access checks
//
// Purpose : Pure combinational helper. Extracts and extends load data from a
//           memory word, merges sub-word store data into a word, and flags
//           illegal funct3 codes and misaligned accesses.
// Ports   : word_i      memory word (read data)
//           offset_i    byte offset inside the word (addr[1:0])
//           funct3_i    RV32 size/sign code
//           write_i     1 = store, 0 = load (selects legal funct3 set)
//           wdata_i     right-aligned store data
//           load_val_o  shifted and extended load value
//           store_word_o word with the store data merged into its lane(s)
//           misalign_o  halfword/word access not naturally aligned
//           illegal_o   funct3 not a legal code for this direction
module dmem_lane_align
  import dmem_ctrl_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  input  logic        write_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_val_o,
  output logic [31:0] store_word_o,
  output logic        misalign_o,
  output logic        illegal_o
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [31:0] shifted;
  logic [31:0] byte_mask;
  logic [31:0] half_mask;

  assign byte_sh   = {offset_i, 3'b000};
  // Halfwords occupy lanes 0-1 or 2-3; offset bit 0 is a misalignment, not a shift.
  assign half_sh   = {offset_i[1], 4'b0000};
  assign shifted   = word_i >> byte_sh;
  assign byte_mask = 32'h0000_00FF << byte_sh;
  assign half_mask = 32'h0000_FFFF << half_sh;

  always_comb begin
    load_val_o = word_i;
    case (funct3_i)
      F3_B:    load_val_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_val_o = {24'h0, shifted[7:0]};
      F3_H:    load_val_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_val_o = {16'h0, shifted[15:0]};
      default: load_val_o = word_i;
    endcase
  end

  always_comb begin
    store_word_o = wdata_i;
    case (funct3_i)
      F3_B:    store_word_o = (word_i & ~byte_mask) | ({24'h0, wdata_i[7:0]} << byte_sh);
      F3_H:    store_word_o = (word_i & ~half_mask) | ({16'h0, wdata_i[15:0]} << half_sh);
      default: store_word_o = wdata_i;
    endcase
  end

  always_comb begin
    misalign_o = 1'b0;
    if (funct3_i == F3_H || funct3_i == F3_HU) misalign_o = offset_i[0];
    else if (funct3_i == F3_W)                 misalign_o = (offset_i != 2'b00);
  end

  always_comb begin
    if (write_i) illegal_o = !(funct3_i == F3_B || funct3_i == F3_H || funct3_i == F3_W);
    else         illegal_o = !(funct3_i == F3_B || funct3_i == F3_H || funct3_i == F3_W ||
                               funct3_i == F3_BU || funct3_i == F3_HU);
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - RV32 load/store sequencer for a negedge word memory
//
// Purpose : Accepts one load/store at a time, drives word-aligned memory
//           accesses, performs read-modify-write for SB/SH, and returns one
//           response pulse per accepted request.
// Ports   : clk_i, rst_ni                 clock, async active-low reset
//           req_valid_i/req_ready_o       request handshake (ready only in IDLE)
//           req_write_i, req_funct3_i     direction and size/sign code
//           req_addr_i, req_wdata_i       byte address, right-aligned store data
//           resp_valid_o, resp_rdata_o,   one-cycle response with load data
//           resp_err_o                    and misaligned/illegal flag
//           mem_read_o, mem_write_o       memory enables
//           mem_address_o, mem_data_in_o  word address and write word
//           mem_data_out_i                memory read word
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 20
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              resp_valid_o,
  output logic [31:0]       resp_rdata_o,
  output logic              resp_err_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [31:0]       mem_data_in_o,
  input  logic [31:0]       mem_data_out_i
);

  state_t            state_q, state_d;
  logic              write_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       wbuf_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              idle;
  logic              accept;
  logic [2:0]        sel_f3;
  logic [1:0]        sel_off;
  logic              sel_write;
  logic [31:0]       load_val;
  logic [31:0]       store_word;
  logic              misalign;
  logic              illegal;
  logic              req_bad;

  assign idle   = (state_q == IDLE);
  assign accept = idle && req_valid_i;

  // In IDLE the checker looks at the live request; afterwards at the latched one.
  assign sel_f3    = idle ? req_funct3_i   : f3_q;
  assign sel_off   = idle ? req_addr_i[1:0] : addr_q[1:0];
  assign sel_write = idle ? req_write_i    : write_q;

  dmem_lane_align u_align (
    .word_i       (mem_data_out_i),
    .offset_i     (sel_off),
    .funct3_i     (sel_f3),
    .write_i      (sel_write),
    .wdata_i      (wdata_q),
    .load_val_o   (load_val),
    .store_word_o (store_word),
    .misalign_o   (misalign),
    .illegal_o    (illegal)
  );

  assign req_bad = misalign || illegal;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (req_bad)                     state_d = RESP;
          else if (!req_write_i)           state_d = RD;
          else if (req_funct3_i == F3_W)   state_d = WR;
          else                             state_d = RD;
        end
      end
      RD:      state_d = write_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory strobes decode only from flops so they are settled well before the negedge.
  always_comb begin
    req_ready_o  = (state_q == IDLE);
    mem_read_o   = (state_q == RD);
    mem_write_o  = (state_q == WR);
    resp_valid_o = (state_q == RESP);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      write_q <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      wbuf_q  <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else if (accept) begin
      write_q <= req_write_i;
      f3_q    <= req_funct3_i;
      addr_q  <= req_addr_i;
      wdata_q <= req_wdata_i;
      wbuf_q  <= req_wdata_i;
      rdata_q <= 32'h0;
      err_q   <= req_bad;
    end else if (state_q == RD) begin
      if (write_q) wbuf_q  <= store_word;
      else         rdata_q <= load_val;
    end
  end

  assign resp_rdata_o  = rdata_q;
  assign resp_err_o    = err_q;
  assign mem_address_o = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_data_in_o = wbuf_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - directed self-checking bench for dmem_access_ctrl
module tb_dmem_access_ctrl;

  localparam int ADDR_W = 20;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_data_in;
  logic [31:0]       mem_data_out;

  int checks = 0;
  int errors = 0;

  dmem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_write_i    (req_write),
    .req_funct3_i   (req_funct3),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .resp_valid_o   (resp_valid),
    .resp_rdata_o   (resp_rdata),
    .resp_err_o     (resp_err),
    .mem_read_o     (mem_read),
    .mem_write_o    (mem_write),
    .mem_address_o  (mem_address),
    .mem_data_in_o  (mem_data_in),
    .mem_data_out_i (mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Negedge-clocked word memory; read data forced to 0 when not reading.
  logic [31:0] mem [0:1023];
  logic [31:0] mem_rd_q = 32'h0;
  always @(negedge clk) begin
    if (mem_read)  mem_rd_q <= mem[mem_address[11:2]];
    if (mem_write) mem[mem_address[11:2]] <= mem_data_in;
  end
  assign mem_data_out = mem_read ? mem_rd_q : 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  int               r_lat;
  logic [31:0]      r_rdata;
  logic             r_err;
  logic             r_saw_rd;
  logic             r_saw_wr;
  logic [31:0]      r_wr_data;
  logic [ADDR_W-1:0] r_rd_addr;

  // Issues one request and returns the latency in edges after E0 plus what the memory saw.
  task automatic run_req(input logic w, input logic [2:0] f3,
                         input logic [ADDR_W-1:0] a, input logic [31:0] wd);
    r_lat = -1; r_rdata = 32'h0; r_err = 1'b0;
    r_saw_rd = 1'b0; r_saw_wr = 1'b0; r_wr_data = 32'h0; r_rd_addr = '0;
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (resp_valid) begin
        r_lat = n; r_rdata = resp_rdata; r_err = resp_err;
        break;
      end
      if (mem_read)  begin r_saw_rd = 1'b1; r_rd_addr = mem_address; end
      if (mem_write) begin r_saw_wr = 1'b1; r_wr_data = mem_data_in; end
      @(posedge clk); #1;
    end
    if (r_lat < 0) check("resp_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    check("ready_after", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3,
                         input logic [ADDR_W-1:0] a, input logic [31:0] exp);
    run_req(1'b0, f3, a, 32'h0);
    check({tag, "_rdata"}, r_rdata, exp);
    check({tag, "_lat"}, r_lat, 32'd1);
    check({tag, "_err"}, {31'd0, r_err}, 32'd0);
  endtask

  task automatic do_err(input string tag, input logic w, input logic [2:0] f3,
                        input logic [ADDR_W-1:0] a);
    run_req(w, f3, a, 32'hFFFF_FFFF);
    check({tag, "_err"}, {31'd0, r_err}, 32'd1);
    check({tag, "_lat"}, r_lat, 32'd0);
    check({tag, "_rdata"}, r_rdata, 32'h0);
    check({tag, "_memop"}, {30'd0, r_saw_rd, r_saw_wr}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_funct3 = 3'b000; req_addr = '0; req_wdata = 32'h0;
    #12;
    check("rst_ready",    {31'd0, req_ready},  32'd1);
    check("rst_rvalid",   {31'd0, resp_valid}, 32'd0);
    check("rst_rdata",    resp_rdata,          32'h0);
    check("rst_err",      {31'd0, resp_err},   32'd0);
    check("rst_mem_rw",   {30'd0, mem_read, mem_write}, 32'd0);
    check("rst_mem_addr", {12'd0, mem_address}, 32'h0);
    check("rst_mem_din",  mem_data_in,         32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // SW establishes the test word; no read phase.
    run_req(1'b1, 3'b010, 20'h00100, 32'h80FF1234);
    check("sw1_lat",  r_lat, 32'd1);
    check("sw1_rd",   {31'd0, r_saw_rd}, 32'd0);
    check("sw1_wr",   {31'd0, r_saw_wr}, 32'd1);
    check("sw1_data", r_wr_data, 32'h80FF1234);

    run_req(1'b0, 3'b000, 20'h00103, 32'h0);
    check("lb_rdata", r_rdata, 32'hFFFFFF80);
    check("lb_lat",   r_lat, 32'd1);
    check("lb_addr",  {12'd0, r_rd_addr}, 32'h00100);
    check("lb_rd",    {31'd0, r_saw_rd}, 32'd1);
    check("lb_wr",    {31'd0, r_saw_wr}, 32'd0);
    do_load("lhu", 3'b101, 20'h00102, 32'h000080FF);
    do_load("lh",  3'b001, 20'h00102, 32'hFFFF80FF);
    do_load("lbu", 3'b100, 20'h00100, 32'h00000034);
    do_load("lh0", 3'b001, 20'h00100, 32'h00001234);
    do_load("lb2", 3'b000, 20'h00102, 32'hFFFFFFFF);

    // Read-modify-write: only the addressed byte lane changes.
    run_req(1'b1, 3'b010, 20'h00100, 32'h11223344);
    run_req(1'b1, 3'b000, 20'h00101, 32'h123456AA);
    check("sb_lat",  r_lat, 32'd2);
    check("sb_rd",   {31'd0, r_saw_rd}, 32'd1);
    check("sb_wr",   {31'd0, r_saw_wr}, 32'd1);
    check("sb_data", r_wr_data, 32'h1122AA44);
    check("sb_err",  {31'd0, r_err}, 32'd0);
    do_load("lw_sb", 3'b010, 20'h00100, 32'h1122AA44);

    run_req(1'b1, 3'b001, 20'h00102, 32'h9999BEEF);
    check("sh_lat",  r_lat, 32'd2);
    check("sh_data", r_wr_data, 32'hBEEFAA44);
    do_load("lw_sh", 3'b010, 20'h00100, 32'hBEEFAA44);

    run_req(1'b1, 3'b010, 20'h00200, 32'hDEADBEEF);
    check("sw2_lat",  r_lat, 32'd1);
    check("sw2_rd",   {31'd0, r_saw_rd}, 32'd0);
    check("sw2_data", r_wr_data, 32'hDEADBEEF);

    do_err("lw_mis",  1'b0, 3'b010, 20'h00202);
    do_err("ld_f3_3", 1'b0, 3'b011, 20'h00200);
    do_err("ld_f3_6", 1'b0, 3'b110, 20'h00200);
    do_err("sh_mis",  1'b1, 3'b001, 20'h00201);
    do_err("st_f3_4", 1'b1, 3'b100, 20'h00200);
    do_err("lhu_mis", 1'b0, 3'b101, 20'h00203);
    do_load("lw_keep", 3'b010, 20'h00200, 32'hDEADBEEF);

    // Reset during the WR cycle of an SH, before the memory's negedge.
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b001;
    req_addr = 20'h00200; req_wdata = 32'h00005555;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_sh_rd", {31'd0, mem_read}, 32'd1);
    @(posedge clk); #1;
    check("rst_sh_wr", {31'd0, mem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_sh_wr_off", {31'd0, mem_write}, 32'd0);
    check("rst_sh_rv",     {31'd0, resp_valid}, 32'd0);
    check("rst_sh_addr",   {12'd0, mem_address}, 32'h0);
    check("rst_sh_din",    mem_data_in, 32'h0);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      check("rst_sh_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    check("rst_sh_ready", {31'd0, req_ready}, 32'd1);
    do_load("lw_after_rst", 3'b010, 20'h00200, 32'hDEADBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Load/store sequencer between the core's memory stage and the word-wide, negedge-clocked data memory. Accepts one RV32 load/store at a time (LB/LH/LW/LBU/LHU/SB/SH/SW), always drives word-aligned addresses, and performs read-modify-write for sub-word stores. It extracts and sign- or zero-extends load data, flags misaligned or illegal requests without touching memory, and returns one response pulse per accepted request.

## Interface
- ADDR_W, 20: byte-address width; equals the data memory address width.
- Clk  in  1  system clock; all controller flops are posedge.
- Rst_N  in  1  asynchronous, active-low reset.
- Req_Valid  in  1  request present.
- Req_Ready  out  1  controller can accept; high only in IDLE.
- Req_Write  in  1  1 = store, 0 = load.
- Req_Funct3  in  3  RV32 funct3 size/sign code.
- Req_Addr  in  ADDR_W  byte address.
- Req_Wdata  in  32  store data, right-aligned.
- Resp_Valid  out  1  one-cycle response pulse.
- Resp_Rdata  out  32  extended load data; 0 for stores and errors.
- Resp_Err  out  1  request was misaligned or illegal; valid with Resp_Valid.
- Mem_Read  out  1  data memory read enable.
- Mem_Write  out  1  data memory write enable.
- Mem_Address  out  ADDR_W  always {addr[ADDR_W-1:2], 2'b00}.
- Mem_Data_In  out  32  write word to memory.
- Mem_Data_Out  in  32  read word from memory; memory forces 0 when Mem_Read is low.

## Operation
- States: IDLE, RD, WR, RESP.
- IDLE: Req_Ready=1. On Req_Valid, latch write, funct3, addr, and wdata.
  - Illegal funct3 (load: 011, 11x; store: anything other than 000/001/010), or misaligned access (H with addr[0]=1, W with addr[1:0]≠0): go to RESP with error.
  - Legal load: go to RD.
  - SW: go to WR with wbuf=Req_Wdata.
  - SB/SH: go to RD.
- RD: Mem_Read=1. At the next posedge, capture Mem_Data_Out.
  - Load: shift by addr[1:0]×8, sign- or zero-extend per funct3 into rdata_q, then go to RESP.
  - SB/SH: merge wdata byte/half into lane addr[1:0] of the captured word, keeping the other lanes, into wbuf, then go to WR.
- WR: Mem_Write=1, Mem_Data_In=wbuf. Go to RESP.
- RESP: Resp_Valid=1 for exactly one cycle; no backpressure. Then go to IDLE.
- Mem_Read, Mem_Write, and Mem_Address decode only from flops, so they settle a half cycle before the memory's negedge.
- Reset (async): state=IDLE. Resp_Valid=0, Resp_Err=0, Resp_Rdata=0, Mem_Read=0, Mem_Write=0, Mem_Address=0, Mem_Data_In=0. Internal registers clear to 0.
- Reset asserted in WR before the negedge: the write is suppressed. The request is dropped and no response is issued.

## Timing
- Request accepted at posedge E0.
- Responses (Resp_Valid high during the cycle after edge E_n):
  - Error: E0.
  - SW: E1.
  - Load: E1.
  - SB/SH: E2.
- Issue-to-issue throughput: error 2, load/SW 3, SB/SH 4 cycles.
- Memory read data is sampled on the posedge closing the RD cycle. The memory updated it at the mid-cycle negedge.
- Req_Valid held while Req_Ready=0 is ignored; the requester must hold the request until IDLE.

## Structure
- Package dmem_ctrl_pkg holds:
  - state_t enum (IDLE, RD, WR, RESP).
  - Funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
- Sub-module dmem_lane_align (combinational) takes word, offset, funct3, and wdata. It produces the extended load value, the merged store word, and the misalign/illegal flags.
- The FSM and registers live in dmem_access_ctrl.

## Test plan
- LB at 0x00103, memory word 0x80FF1234 at 0x00100 -> RD cycle with Mem_Address=0x00100; Resp_Rdata=0xFFFFFF80 at E1; Resp_Err=0.
- LHU at 0x00102, same word -> Resp_Rdata=0x000080FF.
- SB of 0xAA at 0x00101, memory word 0x11223344 -> Mem_Read, then Mem_Write with Mem_Data_In=0x1122AA44; response at E2; a following LW returns 0x1122AA44.
- SW of 0xDEADBEEF at 0x00200 -> no Mem_Read; one Mem_Write cycle; response at E1.
- LW at 0x00202, and funct3=011 load -> Resp_Err=1 at E0; Mem_Read and Mem_Write never asserted; memory unchanged.
- Rst_N pulsed low during the WR of an SH -> outputs reset immediately; target word unchanged; no Resp_Valid; Req_Ready=1 after release.
